rl_lj_force_accumulator: RTL and testbench
==========================================

RL_LJ_FORCE_ACCUMULATOR -- requirements
Module: rl_lj_force_accumulator

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each signed two's-complement per-pair force component.
REQ-002 Parameter ACC_WIDTH, default 40: width of each accumulated force component; SHALL be >= DATA_WIDTH.
REQ-003 Parameter ID_WIDTH, default 16: width of the reference-particle identifier.
REQ-004 Parameter CNT_WIDTH, default 10: width of the per-group pair counter.
REQ-005 Parameter FIFO_DEPTH, default 4: result FIFO entries; power of two, >= 2.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 clock  in  1  the single clock; all state updates on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 ivalid  in  1  input beat valid.
REQ-010 iready  out  1  block can accept a beat.
REQ-011 ilast  in  1  beat is the last neighbour pair of the current reference particle.
REQ-012 ref_id  in  ID_WIDTH  reference particle id; sampled on the first beat of a group only.
REQ-013 force_x / force_y / force_z  in  DATA_WIDTH each  signed per-pair force components.
REQ-014 ovalid  out  1  result at FIFO head valid.
REQ-015 oready  in  1  downstream accepts result.
REQ-016 acc_x / acc_y / acc_z  out  ACC_WIDTH each  signed accumulated force components.
REQ-017 out_ref_id  out  ID_WIDTH; out_count  out  CNT_WIDTH  pairs in group; out_sat  out  1  saturation occurred in group.

Function
REQ-018 A beat SHALL be accepted iff ivalid && iready at a rising edge; iready = (FIFO occupancy < FIFO_DEPTH), independent of ivalid.
REQ-019 FSM states: IDLE (no open group), ACCUM (group open); IDLE->ACCUM on accepted beat with ilast=0; ACCUM->IDLE on accepted beat with ilast=1; IDLE->IDLE on accepted beat with ilast=1 (single-beat group).
REQ-020 First beat of a group SHALL load the accumulator with sign-extended forces, capture ref_id, set count=1 and clear sat; later beats add sign-extended forces and increment count.
REQ-021 Each component addition SHALL saturate to +(2^(ACC_WIDTH-1)-1) / -(2^(ACC_WIDTH-1)); any saturating component sets the group's sticky sat flag.
REQ-022 count SHALL saturate at 2^CNT_WIDTH-1 without wrapping.
REQ-023 On an accepted ilast beat, the final (post-add) sums, id, count and sat SHALL be written into the FIFO at that same edge; ovalid SHALL be high in the next cycle (latency 1 from last-beat accept).
REQ-024 ref_id on non-first beats SHALL be ignored.
REQ-025 A result SHALL pop when ovalid && oready; outputs SHALL hold stable while ovalid=1 and oready=0.
REQ-026 Push and pop in the same cycle SHALL be permitted at any occupancy < FIFO_DEPTH, leaving occupancy unchanged.
REQ-027 Results SHALL leave in acceptance order; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-028 An open group SHALL persist across cycles with ivalid=0 or iready=0 without change.

Reset
REQ-029 While rst=1: ovalid=0, FIFO empty, FSM=IDLE, accumulators/count/sat=0, acc_*/out_* outputs=0, iready=0.
REQ-030 Reset mid-group SHALL discard the open group and all queued results; iready=1 the cycle after rst deasserts.

Structure
REQ-031 Package rl_lj_pkg SHALL hold default width constants and the signed saturating-add function.
REQ-032 The result FIFO SHALL be a sub-module rl_lj_result_fifo (parametrised width/depth, registered outputs, full/empty/count).

Verification (DATA_WIDTH=32, ACC_WIDTH=40, FIFO_DEPTH=4, integer forces)
REQ-033 Beats (1,2,4),(2,2,2),(1,4,8), ilast on third, ref_id=7 -> one cycle later ovalid=1, acc=(4,8,14), out_ref_id=7, out_count=3, out_sat=0.
REQ-034 Single beat (-5,3,0) ilast=1 -> acc=(-5,3,0), out_count=1; back-to-back single-beat groups every cycle with oready=1 -> one result per cycle, iready never drops.
REQ-035 oready=0, five single-beat groups -> iready=0 after 4th accept, 5th held; oready=1 -> results 1..5 emerge in order, 5th accepted the cycle after the first pop.
REQ-036 300 beats of force_x=0x7FFFFFFF, ilast on 300th -> acc_x=549755813887, out_sat=1, out_count=300.
REQ-037 Two beats (1,1,1), rst for 1 cycle, then single beat (2,0,0) ilast=1 -> only result acc=(2,0,0), out_count=1.
REQ-038 FIFO holds 1 result, oready=1 and ilast beat accepted same cycle -> occupancy stays 1, next result appears next cycle.

Source files
------------

// File: rtl/rl_lj_pkg.sv
// Shared width defaults and the signed saturating adder used by the LJ force accumulator.
package rl_lj_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ACC_WIDTH  = 40;
    localparam int DEF_ID_WIDTH   = 16;
    localparam int DEF_CNT_WIDTH  = 10;
    localparam int DEF_FIFO_DEPTH = 4;

    // Arithmetic carrier for the adder; accumulator widths up to SAT_WIDTH-1 bits fit.
    localparam int SAT_WIDTH = 64;

    typedef struct packed {
        logic signed [SAT_WIDTH-1:0] sum;
        logic                        sat;
    } sat_res_t;

    // Operands are sign-extended values that already fit in w bits; the result is clamped to w bits.
    function automatic sat_res_t sat_add(input logic signed [SAT_WIDTH-1:0] a,
                                         input logic signed [SAT_WIDTH-1:0] b,
                                         input int                          w);
        logic signed [SAT_WIDTH:0] s;
        logic signed [SAT_WIDTH:0] hi;
        logic signed [SAT_WIDTH:0] lo;
        sat_res_t                  r;
        s  = {a[SAT_WIDTH-1], a} + {b[SAT_WIDTH-1], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        if (s > hi) begin
            r.sum = hi[SAT_WIDTH-1:0];
            r.sat = 1'b1;
        end else if (s < lo) begin
            r.sum = lo[SAT_WIDTH-1:0];
            r.sat = 1'b1;
        end else begin
            r.sum = s[SAT_WIDTH-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rl_lj_result_fifo.sv
// Result queue for completed groups; head entry and status flags come straight from registers.
module rl_lj_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      nxt_count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        nxt_count = count;
        if (do_push && !do_pop) begin
            nxt_count = count + 1'b1;
        end else if (!do_push && do_pop) begin
            nxt_count = count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= nxt_count;
            full  <= (nxt_count == DEPTH_CNT);
            empty <= (nxt_count == '0);
        end
    end

endmodule

// File: rtl/rl_lj_force_accumulator.sv
// Sums per-pair LJ force components per reference particle with saturation and queues one result per group.
module rl_lj_force_accumulator
    import rl_lj_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         ivalid,
    output logic                         iready,
    input  logic                         ilast,
    input  logic [ID_WIDTH-1:0]          ref_id,
    input  logic signed [DATA_WIDTH-1:0] force_x,
    input  logic signed [DATA_WIDTH-1:0] force_y,
    input  logic signed [DATA_WIDTH-1:0] force_z,
    output logic                         ovalid,
    input  logic                         oready,
    output logic signed [ACC_WIDTH-1:0]  acc_x,
    output logic signed [ACC_WIDTH-1:0]  acc_y,
    output logic signed [ACC_WIDTH-1:0]  acc_z,
    output logic [ID_WIDTH-1:0]          out_ref_id,
    output logic [CNT_WIDTH-1:0]         out_count,
    output logic                         out_sat
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;
    localparam int RES_W = 3 * ACC_WIDTH + ID_WIDTH + CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [0:0]                  state;
    logic signed [ACC_WIDTH-1:0] sum_x, sum_y, sum_z;
    logic [ID_WIDTH-1:0]         grp_id;
    logic [CNT_WIDTH-1:0]        grp_cnt;
    logic                        grp_sat;

    logic                        first;
    logic                        accept;
    logic                        push;
    logic signed [SAT_WIDTH-1:0] base_x, base_y, base_z;
    sat_res_t                    res_x, res_y, res_z;
    logic signed [ACC_WIDTH-1:0] nxt_x, nxt_y, nxt_z;
    logic [ID_WIDTH-1:0]         nxt_id;
    logic [CNT_WIDTH-1:0]        nxt_cnt;
    logic                        nxt_sat;

    logic [RES_W-1:0]            fifo_din;
    logic [RES_W-1:0]            fifo_dout;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        unused_bits;

    assign iready = ~rst & ~fifo_full;
    assign ovalid = ~rst & ~fifo_empty;
    assign accept = ivalid & iready;
    assign push   = accept & ilast;

    // A first beat adds onto zero, which reuses the adder to load the sign-extended force.
    always_comb begin
        first   = (state == ST_IDLE);
        base_x  = first ? {SAT_WIDTH{1'b0}} : SAT_WIDTH'(sum_x);
        base_y  = first ? {SAT_WIDTH{1'b0}} : SAT_WIDTH'(sum_y);
        base_z  = first ? {SAT_WIDTH{1'b0}} : SAT_WIDTH'(sum_z);
        res_x   = sat_add(base_x, SAT_WIDTH'(force_x), ACC_WIDTH);
        res_y   = sat_add(base_y, SAT_WIDTH'(force_y), ACC_WIDTH);
        res_z   = sat_add(base_z, SAT_WIDTH'(force_z), ACC_WIDTH);
        nxt_x   = res_x.sum[ACC_WIDTH-1:0];
        nxt_y   = res_y.sum[ACC_WIDTH-1:0];
        nxt_z   = res_z.sum[ACC_WIDTH-1:0];
        nxt_sat = (~first & grp_sat) | res_x.sat | res_y.sat | res_z.sat;
        nxt_id  = first ? ref_id : grp_id;
        if (first) begin
            nxt_cnt = CNT_WIDTH'(1);
        end else if (grp_cnt == CNT_MAX) begin
            nxt_cnt = grp_cnt;
        end else begin
            nxt_cnt = grp_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state   <= ST_IDLE;
            sum_x   <= '0;
            sum_y   <= '0;
            sum_z   <= '0;
            grp_id  <= '0;
            grp_cnt <= '0;
            grp_sat <= 1'b0;
        end else if (accept) begin
            state   <= ilast ? ST_IDLE : ST_ACCUM;
            sum_x   <= nxt_x;
            sum_y   <= nxt_y;
            sum_z   <= nxt_z;
            grp_id  <= nxt_id;
            grp_cnt <= nxt_cnt;
            grp_sat <= nxt_sat;
        end
    end

    assign fifo_din = {nxt_x, nxt_y, nxt_z, nxt_id, nxt_cnt, nxt_sat};
    assign {acc_x, acc_y, acc_z, out_ref_id, out_count, out_sat} = fifo_dout;

    rl_lj_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_din),
        .pop       (ovalid & oready),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Adder headroom bits are discarded once the result is clamped to ACC_WIDTH.
    assign unused_bits = ^{res_x.sum[SAT_WIDTH-1:ACC_WIDTH], res_y.sum[SAT_WIDTH-1:ACC_WIDTH],
                           res_z.sum[SAT_WIDTH-1:ACC_WIDTH], fifo_count};

endmodule

// File: tb/tb_rl_lj_force_accumulator.sv
// Scoreboard bench: stimulus pushes expected group results, a negedge monitor pops and compares.
module tb_rl_lj_force_accumulator;

    localparam int DW = 32;
    localparam int AW = 40;
    localparam int IW = 16;
    localparam int CW = 10;
    localparam int FD = 4;
    localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 64'sd1;
    localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));
    localparam int CNT_MAX = (1 << CW) - 1;

    logic                 clock = 1'b0;
    logic                 rst = 1'b1;
    logic                 ivalid = 1'b0;
    logic                 ilast = 1'b0;
    logic                 oready = 1'b0;
    logic [IW-1:0]        ref_id = '0;
    logic signed [DW-1:0] force_x = '0;
    logic signed [DW-1:0] force_y = '0;
    logic signed [DW-1:0] force_z = '0;
    logic                 iready;
    logic                 ovalid;
    logic signed [AW-1:0] acc_x, acc_y, acc_z;
    logic [IW-1:0]        out_ref_id;
    logic [CW-1:0]        out_count;
    logic                 out_sat;

    typedef struct {
        longint x;
        longint y;
        longint z;
        int     id;
        int     cnt;
        bit     sat;
    } res_t;

    res_t   exp_q[$];
    longint m_x, m_y, m_z;
    int     m_id, m_cnt;
    bit     m_sat, m_open;
    int     n_checks = 0;
    int     n_pass = 0;
    bit     rand_ordy = 1'b0;
    int     w;

    always #5 clock = ~clock;

    rl_lj_force_accumulator #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .ID_WIDTH   (IW),
        .CNT_WIDTH  (CW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .ivalid     (ivalid),
        .iready     (iready),
        .ilast      (ilast),
        .ref_id     (ref_id),
        .force_x    (force_x),
        .force_y    (force_y),
        .force_z    (force_z),
        .ovalid     (ovalid),
        .oready     (oready),
        .acc_x      (acc_x),
        .acc_y      (acc_y),
        .acc_z      (acc_z),
        .out_ref_id (out_ref_id),
        .out_count  (out_count),
        .out_sat    (out_sat)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a group is a running sum per axis, clamped after every addition.
    task automatic model_accept(input longint fx, input longint fy, input longint fz,
                                input int id, input bit last);
        longint s[3];
        longint f[3];
        if (!m_open) begin
            m_x = 0; m_y = 0; m_z = 0;
            m_cnt = 0; m_sat = 1'b0; m_id = id & 16'hFFFF;
        end
        s = '{m_x, m_y, m_z};
        f = '{fx, fy, fz};
        for (int i = 0; i < 3; i++) begin
            s[i] = s[i] + f[i];
            if (s[i] > ACC_MAX) begin s[i] = ACC_MAX; m_sat = 1'b1; end
            else if (s[i] < ACC_MIN) begin s[i] = ACC_MIN; m_sat = 1'b1; end
        end
        m_x = s[0]; m_y = s[1]; m_z = s[2];
        if (m_cnt < CNT_MAX) m_cnt++;
        if (last) begin
            exp_q.push_back('{m_x, m_y, m_z, m_id, m_cnt, m_sat});
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken, ivalid left high.
    task automatic send_beat(input int fx, input int fy, input int fz, input int id,
                             input bit last, output int waited);
        waited  = 0;
        ivalid  = 1'b1;
        force_x = fx;
        force_y = fy;
        force_z = fz;
        ref_id  = id[IW-1:0];
        ilast   = last;
        @(negedge clock);
        while (!iready && waited < 500) begin
            waited++;
            @(negedge clock);
        end
        if (!iready) begin
            check("iready_timeout", 0, 1);
            ivalid = 1'b0;
            return;
        end
        @(posedge clock);
        model_accept(fx, fy, fz, id, last);
        #1;
    endtask

    task automatic idle(input int n);
        ivalid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(posedge clock) begin
        if (rand_ordy) begin
            #1 oready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clock) begin : monitor
        res_t e;
        if (!rst && ovalid && oready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("acc_x", acc_x, e.x);
                check("acc_y", acc_y, e.y);
                check("acc_z", acc_z, e.z);
                check("out_ref_id", out_ref_id, e.id);
                check("out_count", out_count, e.cnt);
                check("out_sat", out_sat, e.sat);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int fmax;
        int fmin;
        int len;
        fmax = 32'h7FFF_FFFF;
        fmin = 32'h8000_0000;

        // Reset state
        @(posedge clock);
        @(negedge clock);
        check("rst_iready", iready, 0);
        check("rst_ovalid", ovalid, 0);
        check("rst_acc_x", acc_x, 0);
        check("rst_out_count", out_count, 0);
        @(posedge clock);
        #1 rst = 1'b0;
        @(negedge clock);
        check("post_rst_iready", iready, 1);
        @(posedge clock);
        #1;

        // Three-beat group; later ref_ids must be ignored
        oready = 1'b1;
        send_beat(1, 2, 4, 7, 1'b0, w);
        send_beat(2, 2, 2, 99, 1'b0, w);
        send_beat(1, 4, 8, 123, 1'b1, w);
        ivalid = 1'b0;
        @(negedge clock);
        check("latency_ovalid", ovalid, 1);
        idle(2);

        // Single-beat groups back to back: iready never drops
        send_beat(-5, 3, 0, 1, 1'b1, w);
        check("b2b_wait", w, 0);
        for (int i = 0; i < 8; i++) begin
            send_beat(int'($urandom), int'($urandom), int'($urandom), i + 20, 1'b1, w);
            check("b2b_wait", w, 0);
        end
        idle(3);

        // Fill the FIFO, hold the fifth beat, release on first pop
        oready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send_beat(10 * k, -k, k, k, 1'b1, w);
        end
        ivalid = 1'b1; force_x = 50; force_y = -5; force_z = 5; ref_id = 5; ilast = 1'b1;
        repeat (3) @(negedge clock);
        check("full_iready", iready, 0);
        check("full_ovalid", ovalid, 1);
        @(posedge clock);
        #1 oready = 1'b1;
        @(negedge clock);
        check("iready_before_pop", iready, 0);
        @(posedge clock);
        @(negedge clock);
        check("iready_after_pop", iready, 1);
        @(posedge clock);
        model_accept(50, -5, 5, 5, 1'b1);
        #1;
        idle(8);

        // Simultaneous push and pop with one entry queued
        oready = 1'b0;
        send_beat(111, 222, 333, 60, 1'b1, w);
        oready = 1'b1;
        send_beat(-111, -222, -333, 61, 1'b1, w);
        ivalid = 1'b0;
        @(negedge clock);
        check("pushpop_ovalid", ovalid, 1);
        @(posedge clock);
        @(negedge clock);
        check("pushpop_drained", ovalid, 0);
        @(posedge clock);
        #1;

        // Positive and negative saturation over 300 beats, then count saturation
        for (int i = 0; i < 300; i++) send_beat(fmax, 0, 1, 42, i == 299, w);
        for (int i = 0; i < 300; i++) send_beat(0, fmin, -1, 43, i == 299, w);
        for (int i = 0; i < 1100; i++) send_beat(0, 0, 0, 44, i == 1099, w);
        idle(4);

        // Reset discards queued results and an open group
        oready = 1'b0;
        send_beat(7, 7, 7, 70, 1'b1, w);
        send_beat(8, 8, 8, 71, 1'b1, w);
        send_beat(1, 1, 1, 72, 1'b0, w);
        send_beat(1, 1, 1, 72, 1'b0, w);
        ivalid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        m_open = 1'b0;
        @(negedge clock);
        check("midrst_iready", iready, 0);
        @(posedge clock);
        #1 rst = 1'b0;
        @(negedge clock);
        check("midrst_ovalid", ovalid, 0);
        check("midrst_iready_after", iready, 1);
        @(posedge clock);
        #1 oready = 1'b1;
        send_beat(2, 0, 0, 73, 1'b1, w);
        idle(3);

        // Random groups with input bubbles and random downstream stalls
        rand_ordy = 1'b1;
        for (int g = 0; g < 150; g++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                send_beat(int'($urandom), int'($urandom), int'($urandom),
                          int'($urandom_range(0, 65535)), b == len - 1, w);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        ivalid = 1'b0;
        rand_ordy = 1'b0;
        @(posedge clock);
        #2 oready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clock);
        @(negedge clock);
        check("drain_queue", exp_q.size(), 0);
        check("final_ovalid", ovalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
